// File: rtl/low_priority_encoder_16_to_4_pkg.sv
// Shared widths for the 16-to-4 low-priority encoder.
package low_priority_encoder_16_to_4_pkg;

    localparam int LPE_IN_W  = 16;
    localparam int LPE_IDX_W = 4;

endpackage

// File: rtl/low_priority_encoder_16_to_4_lpe_4_to_2.sv
// Combinational 4-to-2 encoder. The lowest set bit wins.
// An all-zero input gives idx=0 with any=0.
module lpe_4_to_2 (
    input  logic [3:0] in,
    output logic [1:0] idx,
    output logic       any
);

    // Encoder with bit 0 at the highest priority.
    always_comb begin
        any = |in;
        idx = 2'd0;
        if (in[0]) begin
            idx = 2'd0;
        end else if (in[1]) begin
            idx = 2'd1;
        end else if (in[2]) begin
            idx = 2'd2;
        end else if (in[3]) begin
            idx = 2'd3;
        end
    end

endmodule

// File: rtl/low_priority_encoder_16_to_4.sv
// Registered 16-to-4 low-priority encoder.
// y is the index of the least-significant set bit of W. f reports |W.
// Both outputs have exactly one cycle of latency.
// y=0 has meaning only when f=1.
module low_priority_encoder_16_to_4
    import low_priority_encoder_16_to_4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LPE_IN_W-1:0]  W,
    output logic [LPE_IDX_W-1:0] y,
    output logic                 f
);

    logic [1:0]           nibble_idx [4];
    logic [3:0]           nibble_any;
    logic [1:0]           group_idx;
    logic                 group_any;
    logic [LPE_IDX_W-1:0] y_d, y_q;
    logic                 f_d, f_q;

    // One encoder per nibble. Each encoder finds the lowest set bit inside its own nibble.
    for (genvar g = 0; g < 4; g++) begin : g_nibble
        lpe_4_to_2 u_nibble (
            .in  (W[4*g +: 4]),
            .idx (nibble_idx[g]),
            .any (nibble_any[g])
        );
    end

    // The second-level encoder selects the lowest nibble that holds any set bit.
    lpe_4_to_2 u_group (
        .in  (nibble_any),
        .idx (group_idx),
        .any (group_any)
    );

    // Concatenate the selected nibble number with the bit index inside that nibble.
    always_comb begin
        y_d = {group_idx, nibble_idx[group_idx]};
        f_d = group_any;
    end

    // Output register. The asynchronous clear discards any captured request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
            f_q <= 1'b0;
        end else begin
            y_q <= y_d;
            f_q <= f_d;
        end
    end

    assign y = y_q;
    assign f = f_q;

endmodule

// File: tb/tb_low_priority_encoder_16_to_4.sv
// Testbench for low_priority_encoder_16_to_4.
// It uses directed table vectors, a one-hot sweep, and hand-written reset and latency sequences.
module tb_low_priority_encoder_16_to_4;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  y;
        logic        f;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] W;
    logic [3:0]  y;
    logic        f;

    int checks = 0;
    int errors = 0;

    low_priority_encoder_16_to_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .W     (W),
        .y     (y),
        .f     (f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] ref_idx(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            if (w[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic check(input string nm, input logic [3:0] ey, input logic ef);
        checks++;
        if (y !== ey || f !== ef) begin
            errors++;
            $display("FAIL %s: got y=%0d f=%b, expected y=%0d f=%b", nm, y, f, ey, ef);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{16'h0001, 4'd0,  1'b1};
        vecs[1]  = '{16'h0002, 4'd1,  1'b1};
        vecs[2]  = '{16'h8000, 4'd15, 1'b1};
        vecs[3]  = '{16'h0154, 4'd2,  1'b1};
        vecs[4]  = '{16'h5558, 4'd3,  1'b1};
        vecs[5]  = '{16'h0000, 4'd0,  1'b0};
        vecs[6]  = '{16'h0010, 4'd4,  1'b1};
        vecs[7]  = '{16'hF100, 4'd8,  1'b1};
        vecs[8]  = '{16'h1000, 4'd12, 1'b1};
        vecs[9]  = '{16'hFFFE, 4'd1,  1'b1};
        vecs[10] = '{16'hC000, 4'd14, 1'b1};
        vecs[11] = '{16'h0A80, 4'd7,  1'b1};

        // Hold reset with all request bits set. The outputs must stay clear.
        rst_n = 1'b0;
        W     = 16'hFFFF;
        #1;
        check("reset_async", 4'd0, 1'b0);
        step();
        step();
        check("reset_held", 4'd0, 1'b0);

        // On release, the first edge captures the current W.
        rst_n = 1'b1;
        check("release_pre_edge", 4'd0, 1'b0);
        step();
        check("release_first_edge", 4'd0, 1'b1);

        // Table of directed vectors.
        foreach (vecs[i]) begin
            W = vecs[i].w;
            step();
            check($sformatf("vec%0d_%h", i, vecs[i].w), vecs[i].y, vecs[i].f);
        end

        // Sweep every one-hot value against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] oh;
            oh = 16'h0001 << i;
            W  = oh;
            step();
            check($sformatf("onehot%0d", i), ref_idx(oh), 1'b1);
        end

        // A few random words against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            W = r;
            step();
            check($sformatf("rand_%h", r), ref_idx(r), |r);
        end

        // Changes to W between edges must not reach the outputs.
        W = 16'h0020;
        step();
        check("hold_base", 4'd5, 1'b1);
        W = 16'h0000;
        #2;
        W = 16'h0001;
        #1;
        check("hold_mid_cycle", 4'd5, 1'b1);
        step();
        check("hold_next_edge", 4'd0, 1'b1);

        // When W changes every cycle, each new W appears one edge later.
        begin
            logic [15:0] seq [6];
            logic [3:0]  prev_y;
            logic        prev_f;
            seq[0] = 16'h0004;
            seq[1] = 16'h0000;
            seq[2] = 16'h0800;
            seq[3] = 16'h0300;
            seq[4] = 16'h8001;
            seq[5] = 16'h4000;
            prev_y = 4'd0;
            prev_f = 1'b1;
            foreach (seq[i]) begin
                W = seq[i];
                #1;
                check($sformatf("b2b_pre%0d", i), prev_y, prev_f);
                step();
                check($sformatf("b2b_post%0d", i), ref_idx(seq[i]), |seq[i]);
                prev_y = ref_idx(seq[i]);
                prev_f = |seq[i];
            end
        end

        // Assert reset mid-run while y=15. The outputs must clear before any clock edge.
        W = 16'h8000;
        step();
        check("midrst_before", 4'd15, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 4'd0, 1'b0);
        W = 16'h0002;
        step();
        check("midrst_held", 4'd0, 1'b0);
        rst_n = 1'b1;
        W = 16'h0100;
        step();
        check("midrst_release", 4'd8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
